hit_writer: RTL and testbench

HIT_WRITER -- requirements
Module: hit_writer

---
 rtl/hit_writer.sv | 172 +++++++++++++++++
 tb/tb_hit_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hit_writer.sv
// Writes one hit-result record of NDWORDS 32-bit words as 16-bit AVMM beats.
// Optional feature macro: HIT_WRITER_MISS_SKIP_EN (skip bus writes for hit=0 records).
module hit_writer #(
  parameter int NDWORDS = 3
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic [31:0] i_baseaddr,
  input  logic [31:0] i_index,
  input  logic        i_hit,
  input  logic [31:0] i_t,
  input  logic [31:0] i_tri_index,
  input  logic        i_valid,
  output logic        o_ready,
  output logic        o_done,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_address,
  output logic [15:0] avm_m0_writedata,
  output logic [1:0]  avm_m0_byteenable,
  input  logic        avm_m0_waitrequest
);

  localparam logic [4:0]  LAST_BEAT = 5'(2 * NDWORDS - 1);
  localparam logic [31:0] STRIDE    = 32'(NDWORDS * 4);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r, state_next_s;
  logic        hit_r;
  logic [31:0] t_r;
  logic [31:0] tri_r;
  logic [4:0]  beat_r;
  logic        write_r;
  logic [31:0] addr_r;
  logic [15:0] data_r;
  logic [1:0]  be_r;
  logic        ready_r;
  logic        done_r;
  logic        beat_done_s;
  logic        last_beat_s;
  logic [31:0] rec_addr_s;

  // Beat k carries the low (even k) or high (odd k) half of record word k/2.
  function automatic logic [15:0] half_sel(input logic [4:0]  beat,
                                           input logic        hit,
                                           input logic [31:0] t,
                                           input logic [31:0] tri_idx);
    logic [31:0] word;
    case (beat[4:1])
      4'd0:    word = {31'b0, hit};
      4'd1:    word = t;
      4'd2:    word = tri_idx;
      default: word = 32'h0;
    endcase
    return beat[0] ? word[31:16] : word[15:0];
  endfunction

  assign beat_done_s = write_r & ~avm_m0_waitrequest;
  assign last_beat_s = (beat_r == LAST_BEAT);
  assign rec_addr_s  = i_baseaddr + i_index * STRIDE;

  // State register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (i_valid) begin
`ifdef HIT_WRITER_MISS_SKIP_EN
          state_next_s = i_hit ? WRITE : DONE;
`else
          state_next_s = WRITE;
`endif
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if (beat_done_s && last_beat_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = WRITE;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Record capture, beat sequencing and registered bus outputs.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hit_r   <= 1'b0;
      t_r     <= 32'h0;
      tri_r   <= 32'h0;
      beat_r  <= 5'd0;
      write_r <= 1'b0;
      addr_r  <= 32'h0;
      data_r  <= 16'h0;
      be_r    <= 2'b00;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            hit_r  <= i_hit;
            t_r    <= i_t;
            tri_r  <= i_tri_index;
            beat_r <= 5'd0;
            if (state_next_s == WRITE) begin
              write_r <= 1'b1;
              addr_r  <= rec_addr_s;
              data_r  <= half_sel(5'd0, i_hit, i_t, i_tri_index);
              be_r    <= 2'b11;
            end
          end
        end
        WRITE: begin
          if (beat_done_s) begin
            if (last_beat_s) begin
              beat_r  <= 5'd0;
              write_r <= 1'b0;
              addr_r  <= 32'h0;
              data_r  <= 16'h0;
              be_r    <= 2'b00;
            end else begin
              beat_r <= beat_r + 5'd1;
              addr_r <= addr_r + 32'd2;
              data_r <= half_sel(beat_r + 5'd1, hit_r, t_r, tri_r);
            end
          end
        end
        default: begin
          write_r <= 1'b0;
          addr_r  <= 32'h0;
          data_r  <= 16'h0;
          be_r    <= 2'b00;
        end
      endcase
    end
  end

  // Handshake outputs follow the upcoming state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ready_r <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      ready_r <= (state_next_s == IDLE);
      done_r  <= (state_next_s == DONE);
    end
  end

  assign o_ready           = ready_r;
  assign o_done            = done_r;
  assign avm_m0_write      = write_r;
  assign avm_m0_address    = addr_r;
  assign avm_m0_writedata  = data_r;
  assign avm_m0_byteenable = be_r;

endmodule

// File: tb/tb_hit_writer.sv
// Directed scoreboard bench for hit_writer (NDWORDS=3); honours HIT_WRITER_MISS_SKIP_EN.
module tb_hit_writer;
  localparam int ND = 3;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic [31:0] i_baseaddr = 32'h0;
  logic [31:0] i_index = 32'h0;
  logic        i_hit = 1'b0;
  logic [31:0] i_t = 32'h0;
  logic [31:0] i_tri_index = 32'h0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        o_done;
  logic        avm_m0_write;
  logic [31:0] avm_m0_address;
  logic [15:0] avm_m0_writedata;
  logic [1:0]  avm_m0_byteenable;
  logic        avm_m0_waitrequest = 1'b0;

  typedef struct packed {
    logic [31:0] a;
    logic [15:0] d;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int popped;
  int stalls;

  hit_writer #(.NDWORDS(ND)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_baseaddr(i_baseaddr), .i_index(i_index),
    .i_hit(i_hit), .i_t(i_t), .i_tri_index(i_tri_index), .i_valid(i_valid),
    .o_ready(o_ready), .o_done(o_done), .avm_m0_write(avm_m0_write),
    .avm_m0_address(avm_m0_address), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_waitrequest(avm_m0_waitrequest)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_record(input logic [31:0] base, input logic [31:0] idx, input logic hit,
                             input logic [31:0] t, input logic [31:0] tri_i);
    logic [31:0] w[ND];
    logic [31:0] a;
    beat_t b;
    w[0] = {31'b0, hit};
    w[1] = t;
    w[2] = tri_i;
    for (int i = 3; i < ND; i++) w[i] = 32'h0;
    a = base + idx * 32'(ND * 4);
    for (int k = 0; k < 2 * ND; k++) begin
      b.a = a + 32'(2 * k);
      b.d = (k % 2 == 1) ? w[k / 2][31:16] : w[k / 2][15:0];
      exp_q.push_back(b);
    end
  endtask

  task automatic drive_rec(input logic [31:0] base, input logic [31:0] idx, input logic hit,
                           input logic [31:0] t, input logic [31:0] tri_i);
    i_baseaddr  = base;
    i_index     = idx;
    i_hit       = hit;
    i_t         = t;
    i_tri_index = tri_i;
  endtask

  // One bus cycle seen at the negedge: compare/pop the scoreboard on each write cycle.
  task automatic bus_cycle(input bit stall);
    beat_t f;
    avm_m0_waitrequest = stall;
    if (avm_m0_write) begin
      chk("byteenable", 32'(avm_m0_byteenable), 32'h3);
      if (exp_q.size() == 0) begin
        chk("extra_write", 32'(avm_m0_write), 32'h0);
      end else begin
        f = exp_q[0];
        chk($sformatf("addr_beat%0d", popped), avm_m0_address, f.a);
        chk($sformatf("data_beat%0d", popped), 32'(avm_m0_writedata), 32'(f.d));
        if (!stall) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
    end
  endtask

  task automatic send_record(input logic [31:0] base, input logic [31:0] idx, input logic hit,
                             input logic [31:0] t, input logic [31:0] tri_i,
                             input int stall_beat, input int stall_n, input int abort_beat);
    bit skip;
    bit got_done;
    bit st;
    int exp_lat;
    skip = 1'b0;
`ifdef HIT_WRITER_MISS_SKIP_EN
    skip = !hit;
`endif
    if (!skip) push_record(base, idx, hit, t, tri_i);
    exp_lat  = skip ? 1 : 2 * ND + 1 + stall_n;
    popped   = 0;
    stalls   = 0;
    got_done = 1'b0;
    @(negedge i_clk);
    chk("ready_before", 32'(o_ready), 32'h1);
    drive_rec(base, idx, hit, t, tri_i);
    i_valid = 1'b1;
    for (int cyc = 1; cyc <= 100 && !got_done; cyc++) begin
      @(negedge i_clk);
      i_valid = 1'b0;
      if (abort_beat >= 0 && popped == abort_beat && avm_m0_write) begin
        avm_m0_waitrequest = 1'b0;
        i_rstn = 1'b0;
        #1;
        chk("abort_write", 32'(avm_m0_write), 32'h0);
        chk("abort_addr", avm_m0_address, 32'h0);
        chk("abort_done", 32'(o_done), 32'h0);
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int j = 0; j < 2 * ND + 2; j++) begin
          @(negedge i_clk);
          chk("abort_no_done", 32'(o_done), 32'h0);
        end
        chk("abort_ready", 32'(o_ready), 32'h1);
        exp_q.delete();
        return;
      end
      st = (popped == stall_beat) && (stalls < stall_n);
      if (st) stalls++;
      bus_cycle(st);
      if (o_done) begin
        got_done = 1'b1;
        chk("done_latency", 32'(cyc), 32'(exp_lat));
        chk("beats_left", 32'(exp_q.size()), 32'h0);
        chk("idle_addr", avm_m0_address, 32'h0);
        chk("idle_data", 32'(avm_m0_writedata), 32'h0);
        chk("idle_be", 32'(avm_m0_byteenable), 32'h0);
      end
    end
    chk("done_seen", 32'(got_done), 32'h1);
    @(negedge i_clk);
    chk("done_pulse", 32'(o_done), 32'h0);
    chk("ready_after", 32'(o_ready), 32'h1);
  endtask

  initial begin
    int acc;
    int nd;
    int d0;
    int d1;
    bit sw;

    // Reset behaviour.
    @(negedge i_clk);
    chk("rst_write", 32'(avm_m0_write), 32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_addr", avm_m0_address, 32'h0);
    chk("rst_data", 32'(avm_m0_writedata), 32'h0);
    chk("rst_be", 32'(avm_m0_byteenable), 32'h0);
    i_rstn = 1'b1;
    @(negedge i_clk);
    chk("rst_ready", 32'(o_ready), 32'h1);

    // Basic record, stalled record, miss record.
    send_record(32'h1000, 32'd2, 1'b1, 32'h0002_8000, 32'd7, -1, 0, -1);
    send_record(32'h1000, 32'd2, 1'b1, 32'h0002_8000, 32'd7, 2, 3, -1);
    send_record(32'h1000, 32'd2, 1'b0, 32'h0002_8000, 32'd7, -1, 0, -1);

    // Reset during beat 3, then a normal record.
    send_record(32'h1000, 32'd2, 1'b1, 32'h0002_8000, 32'd7, -1, 0, 3);
    send_record(32'h4000, 32'd5, 1'b1, 32'hFFFE_4000, 32'hA5A5_1234, -1, 0, -1);

    // Address wrap.
    send_record(32'hFFFF_FFF8, 32'd0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, -1, 0, -1);

    // Back-to-back records with i_valid held high.
    push_record(32'h3000, 32'd1, 1'b1, 32'h0000_1111, 32'd42);
    push_record(32'h2000, 32'd1, 1'b1, 32'hFFFF_0000, 32'h1234_5678);
    popped = 0;
    nd = 0; d0 = 0; d1 = 0; sw = 1'b0;
    @(negedge i_clk);
    drive_rec(32'h3000, 32'd1, 1'b1, 32'h0000_1111, 32'd42);
    i_valid = 1'b1;
    acc = o_ready ? 1 : 0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge i_clk);
      bus_cycle(1'b0);
      if (o_done) begin
        if (nd == 0) d0 = cyc; else d1 = cyc;
        nd++;
      end
      if (acc == 1 && !sw) begin
        drive_rec(32'h2000, 32'd1, 1'b1, 32'hFFFF_0000, 32'h1234_5678);
        sw = 1'b1;
      end
      if (acc == 2 && i_valid) i_valid = 1'b0;
      if (o_ready && i_valid) acc++;
    end
    i_valid = 1'b0;
    chk("b2b_done_count", 32'(nd), 32'd2);
    chk("b2b_first_done", 32'(d0), 32'(2 * ND + 1));
    chk("b2b_spacing", 32'(d1 - d0), 32'(2 * ND + 2));
    chk("b2b_beats_left", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
